merger_tree_out_packer: RTL and testbench
=========================================

Name: merger_tree_out_packer

Overview:
- Sits directly downstream of the 4-wide merger tree root.
- Accepts 128-bit beats (4 x 32-bit sorted records) under the tree's write/ready handshake and packs 4 beats into one 512-bit line.
- Emits each line with a byte address to the memory write path.
- Detects the end-of-run terminator beat, flushes any partial line zero-padded, then reports completion with a line count.

Parameters:
- ADDR_W, 32, width of byte address and base address.
- CNT_W, 32, width of emitted-line counter.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; latches i_base_addr and begins a run. Honoured only in IDLE.
- i_base_addr  in  ADDR_W  byte address of first line; must be 64-byte aligned.
- i_data  in  128  beat from tree; record k at bits [32k+31:32k]; record 0 is the oldest.
- i_write  in  1  beat valid; tree asserts only when o_ready is high.
- o_ready  out  1  drives the tree's out-ready input.
- o_line  out  512  packed line; beat j at bits [128j+127:128j].
- o_addr  out  ADDR_W  byte address of o_line.
- o_line_valid  out  1  line available.
- i_line_ready  in  1  downstream accepts line when high together with o_line_valid.
- o_run_done  out  1  one-cycle pulse at end of run.
- o_line_count  out  CNT_W  lines emitted this run; stable from the o_run_done pulse until the next i_start.

Behaviour:
- Reset (async, any state, mid-run included): state=IDLE; accumulator and slot count cnt cleared; holding register H invalid. All outputs 0 (o_ready, o_line_valid, o_run_done, o_line, o_addr, o_line_count). In-flight data is discarded.
- Storage: accumulator A (4 x 128 bits, slot count cnt 0..3) plus one output holding register H (o_line/o_addr/o_line_valid come directly from H).
- Beat acceptance: accepted when i_write && o_ready.
- Terminator: a beat whose 128 bits are all zero. Key value 0 is reserved as the run terminator.
- States:
  - IDLE: o_ready=0. On i_start: addr_next<=i_base_addr, o_line_count<=0, cnt<=0, go to RUN.
  - RUN: o_ready = !(cnt==3 && H_valid && !i_line_ready).
    - Non-terminator beat: written to slot cnt.
    - If cnt==3: the full line (A with the new beat in slot 3) moves to H in the same edge; o_addr<=addr_next; addr_next+=64; count+=1; cnt<=0. Otherwise cnt+=1.
    - Terminator beat: not stored and not emitted; go to FLUSH.
  - FLUSH: o_ready=0.
    - If cnt==0: go to DONE immediately.
    - Otherwise: when H is free or draining this cycle (!H_valid || i_line_ready), move A to H with slots >= cnt forced to 0; apply the address/count update; cnt<=0; go to DONE.
  - DONE: o_ready=0. Wait until H is empty (last line accepted). Then pulse o_run_done for one cycle and go to IDLE.
- H handshake:
  - H_valid clears on o_line_valid && i_line_ready unless reloaded the same edge (simultaneous drain+load keeps valid=1 with new contents).
  - o_line and o_addr hold stable while valid && !ready.
- Latency: 4th beat accepted at edge N gives o_line_valid=1 after edge N.
- Throughput: one beat per cycle sustained while i_line_ready is held high, with no bubbles.
- Address arithmetic: modulo 2^ADDR_W; wrap is silent.
- Line counter: modulo 2^CNT_W.
- Illegal input: i_write while o_ready=0 is ignored (assertion in bench). i_start outside IDLE is ignored.

Test Plan:
- Steady stream: base=0x1000, 8 non-zero beats then terminator, i_line_ready=1 → 2 lines at 0x1000 and 0x1040, beat order preserved; o_run_done pulses; o_line_count=2; o_ready never drops during data.
- Partial flush: 6 beats (records 1..24) then terminator → line 0 holds records 1..16; line 1 holds records 17..24 in bits [255:0] with [511:256]=0; count=2.
- Backpressure: i_line_ready=0 for 10 cycles during a 12-beat stream → o_ready falls only when cnt==3 and H is full; H contents and o_addr stable throughout; no beat lost or duplicated; all 3 lines correct after release.
- Empty run and aligned end: terminator as first beat → no line emitted, o_run_done with count=0. 4 beats then terminator → exactly 1 line, no zero line.
- Address wrap and start guard: ADDR_W=32, base=0xFFFFFFC0, 8 beats → lines at 0xFFFFFFC0 then 0x00000000. i_start pulsed during RUN → no effect.
- Async reset mid-run: assert i_rst between clock edges with H valid and cnt=2 → all outputs 0 immediately; after release, a new i_start run behaves as a clean first run.

Source files
------------

// File: rtl/merger_tree_out_packer_if.sv
// Handshake and data bundle between the merger tree root, the out packer and the memory write path.
interface merger_tree_out_packer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [127:0]      i_data;
  logic              i_write;
  logic              o_ready;
  logic [511:0]      o_line;
  logic [ADDR_W-1:0] o_addr;
  logic              o_line_valid;
  logic              i_line_ready;
  logic              o_run_done;
  logic [CNT_W-1:0]  o_line_count;

  // Packer side.
  modport slave (
    input  i_start, i_base_addr, i_data, i_write, i_line_ready,
    output o_ready, o_line, o_addr, o_line_valid, o_run_done, o_line_count
  );

  // Tree / memory-path side.
  modport master (
    output i_start, i_base_addr, i_data, i_write, i_line_ready,
    input  o_ready, o_line, o_addr, o_line_valid, o_run_done, o_line_count
  );
endinterface

// File: rtl/merger_tree_out_packer.sv
// Packs 128-bit sorted beats from the merger tree root into 512-bit addressed lines.
// An all-zero beat ends the run: any partial line is flushed zero-padded, then
// o_run_done pulses with the number of lines emitted.
module merger_tree_out_packer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input logic                      i_clk,
  input logic                      i_rst,
  merger_tree_out_packer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_t;

  state_t            state;
  logic [127:0]      acc [4];
  logic [1:0]        cnt;
  logic [511:0]      h_line;
  logic [ADDR_W-1:0] h_addr;
  logic              h_valid;
  logic [ADDR_W-1:0] addr_next;
  logic [CNT_W-1:0]  line_count;
  logic              run_done;

  logic              ready;
  logic              accept;
  logic              is_term;
  logic              h_free;
  logic [511:0]      full_line;
  logic [511:0]      flush_line;

  // Ready only drops when the 4th beat would need H while H is still blocked.
  always_comb begin
    ready     = (state == StRun) && !((cnt == 2'd3) && h_valid && !bus.i_line_ready);
    accept    = bus.i_write && ready;
    is_term   = (bus.i_data == 128'd0);
    h_free    = !h_valid || bus.i_line_ready;
    full_line = {bus.i_data, acc[2], acc[1], acc[0]};
  end

  // Partial line for flush: slots at or above cnt are zero-padded.
  always_comb begin
    flush_line = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(cnt)) flush_line[128*k +: 128] = acc[k];
    end
  end

  // Run control FSM, accumulator and output holding register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= StIdle;
      for (int k = 0; k < 4; k++) acc[k] <= '0;
      cnt        <= '0;
      h_line     <= '0;
      h_addr     <= '0;
      h_valid    <= 1'b0;
      addr_next  <= '0;
      line_count <= '0;
      run_done   <= 1'b0;
    end else begin
      run_done <= 1'b0;
      // Drain first; a load in the same edge below overrides it.
      if (h_valid && bus.i_line_ready) h_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (bus.i_start) begin
            addr_next  <= bus.i_base_addr;
            line_count <= '0;
            cnt        <= '0;
            state      <= StRun;
          end
        end
        StRun: begin
          if (accept) begin
            if (is_term) begin
              state <= StFlush;
            end else if (cnt == 2'd3) begin
              h_line     <= full_line;
              h_addr     <= addr_next;
              h_valid    <= 1'b1;
              addr_next  <= addr_next + ADDR_W'(64);
              line_count <= line_count + CNT_W'(1);
              cnt        <= '0;
            end else begin
              acc[cnt] <= bus.i_data;
              cnt      <= cnt + 2'd1;
            end
          end
        end
        StFlush: begin
          if (cnt == 2'd0) begin
            state <= StDone;
          end else if (h_free) begin
            h_line     <= flush_line;
            h_addr     <= addr_next;
            h_valid    <= 1'b1;
            addr_next  <= addr_next + ADDR_W'(64);
            line_count <= line_count + CNT_W'(1);
            cnt        <= '0;
            state      <= StDone;
          end
        end
        StDone: begin
          if (!h_valid) begin
            run_done <= 1'b1;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_line       = h_line;
  assign bus.o_addr       = h_addr;
  assign bus.o_line_valid = h_valid;
  assign bus.o_run_done   = run_done;
  assign bus.o_line_count = line_count;

endmodule

// File: tb/tb_merger_tree_out_packer.sv
// Directed bench for merger_tree_out_packer: streaming, flush, backpressure, empty run,
// address wrap, start guard and asynchronous reset.
module tb_merger_tree_out_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  merger_tree_out_packer_if #(.ADDR_W(32), .CNT_W(32)) bus ();

  merger_tree_out_packer #(.ADDR_W(32), .CNT_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [511:0] lq[$];
  logic [31:0]  aq[$];
  int done_cnt = 0;
  int w [12];

  // Collect every accepted line and count completion pulses.
  always @(negedge clk) begin
    if (bus.o_line_valid && bus.i_line_ready) begin
      lq.push_back(bus.o_line);
      aq.push_back(bus.o_addr);
    end
    if (bus.o_run_done) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [127:0] mk_beat(input int n);
    return {32'(n + 3), 32'(n + 2), 32'(n + 1), 32'(n)};
  endfunction

  function automatic logic [511:0] mk_line(input int n);
    return {mk_beat(n + 12), mk_beat(n + 8), mk_beat(n + 4), mk_beat(n)};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] d, output int waited);
    waited = 0;
    @(negedge clk);
    while (!bus.o_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("send_ready", 512'(bus.o_ready), 512'(1));
    if (bus.o_ready) begin
      bus.i_data  = d;
      bus.i_write = 1'b1;
      @(posedge clk);
      #1 bus.i_write = 1'b0;
    end
  endtask

  task automatic send_n(input int first_rec, input int nbeats, output int wsum);
    int wt;
    wsum = 0;
    for (int b = 0; b < nbeats; b++) begin
      send(mk_beat(first_rec + 4 * b), wt);
      wsum += wt;
    end
  endtask

  task automatic start_run(input logic [31:0] base);
    @(negedge clk);
    bus.i_base_addr = base;
    bus.i_start     = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int s = done_cnt;
    int k = 0;
    while (done_cnt == s && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_done_once"}, 512'(done_cnt - s), 512'(1));
  endtask

  task automatic clear_q();
    lq.delete();
    aq.delete();
  endtask

  int ws;
  int wt;
  logic have_h;
  logic stable;
  logic saw_block;
  logic [511:0] h0;
  logic [31:0] a0;

  initial begin
    rst              = 1'b1;
    bus.i_start      = 1'b0;
    bus.i_base_addr  = '0;
    bus.i_data       = '0;
    bus.i_write      = 1'b0;
    bus.i_line_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 512'(bus.o_ready), 512'(0));
    chk("rst_valid", 512'(bus.o_line_valid), 512'(0));
    chk("rst_done",  512'(bus.o_run_done), 512'(0));
    chk("rst_line",  bus.o_line, 512'(0));
    chk("rst_addr",  512'(bus.o_addr), 512'(0));
    chk("rst_count", 512'(bus.o_line_count), 512'(0));
    rst = 1'b0;

    // Steady stream
    clear_q();
    start_run(32'h1000);
    send_n(1, 8, ws);
    send(128'd0, wt);
    wait_done("steady");
    chk("steady_no_stall", 512'(ws), 512'(0));
    chk("steady_nlines", 512'(lq.size()), 512'(2));
    if (lq.size() == 2) begin
      chk("steady_line0", lq[0], mk_line(1));
      chk("steady_line1", lq[1], mk_line(17));
      chk("steady_addr0", 512'(aq[0]), 512'(32'h1000));
      chk("steady_addr1", 512'(aq[1]), 512'(32'h1040));
    end
    chk("steady_count", 512'(bus.o_line_count), 512'(2));

    // Partial flush
    clear_q();
    start_run(32'h8000);
    send_n(1, 6, ws);
    send(128'd0, wt);
    wait_done("partial");
    chk("partial_nlines", 512'(lq.size()), 512'(2));
    if (lq.size() == 2) begin
      chk("partial_line0", lq[0], mk_line(1));
      chk("partial_line1", lq[1], {256'd0, mk_beat(21), mk_beat(17)});
      chk("partial_addr1", 512'(aq[1]), 512'(32'h8040));
    end
    chk("partial_count", 512'(bus.o_line_count), 512'(2));

    // Backpressure: downstream stalled for the first 10 cycles of a 12-beat run
    clear_q();
    bus.i_line_ready = 1'b0;
    have_h    = 1'b0;
    stable    = 1'b1;
    saw_block = 1'b0;
    h0        = '0;
    a0        = '0;
    start_run(32'h2000);
    fork
      begin
        for (int b = 0; b < 12; b++) send(mk_beat(1 + 4 * b), w[b]);
        send(128'd0, wt);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (bus.o_line_valid) begin
            if (!have_h) begin
              have_h = 1'b1;
              h0     = bus.o_line;
              a0     = bus.o_addr;
            end else if (bus.o_line !== h0 || bus.o_addr !== a0) begin
              stable = 1'b0;
            end
            if (!bus.o_ready) saw_block = 1'b1;
          end
        end
        @(posedge clk);
        #1 bus.i_line_ready = 1'b1;
      end
    join
    wait_done("bp");
    ws = 0;
    for (int b = 0; b < 12; b++) if (b != 7) ws += w[b];
    chk("bp_other_waits", 512'(ws), 512'(0));
    chk("bp_beat8_wait", 512'(w[7]), 512'(3));
    chk("bp_h_seen", 512'(have_h), 512'(1));
    chk("bp_h_stable", 512'(stable), 512'(1));
    chk("bp_blocked", 512'(saw_block), 512'(1));
    chk("bp_held_line", h0, mk_line(1));
    chk("bp_nlines", 512'(lq.size()), 512'(3));
    if (lq.size() == 3) begin
      chk("bp_line0", lq[0], mk_line(1));
      chk("bp_line1", lq[1], mk_line(17));
      chk("bp_line2", lq[2], mk_line(33));
      chk("bp_addr2", 512'(aq[2]), 512'(32'h2080));
    end
    chk("bp_count", 512'(bus.o_line_count), 512'(3));

    // Empty run
    clear_q();
    start_run(32'h6000);
    send(128'd0, wt);
    wait_done("empty");
    chk("empty_nlines", 512'(lq.size()), 512'(0));
    chk("empty_count", 512'(bus.o_line_count), 512'(0));

    // Aligned end: exactly one line, no zero line
    clear_q();
    start_run(32'h7000);
    send_n(1, 4, ws);
    send(128'd0, wt);
    wait_done("aligned");
    chk("aligned_nlines", 512'(lq.size()), 512'(1));
    if (lq.size() == 1) begin
      chk("aligned_line0", lq[0], mk_line(1));
      chk("aligned_addr0", 512'(aq[0]), 512'(32'h7000));
    end
    chk("aligned_count", 512'(bus.o_line_count), 512'(1));

    // Address wrap plus i_start during RUN
    clear_q();
    start_run(32'hFFFF_FFC0);
    send_n(1, 3, ws);
    start_run(32'h5000);
    send_n(13, 5, ws);
    send(128'd0, wt);
    wait_done("wrap");
    chk("wrap_nlines", 512'(lq.size()), 512'(2));
    if (lq.size() == 2) begin
      chk("wrap_line0", lq[0], mk_line(1));
      chk("wrap_line1", lq[1], mk_line(17));
      chk("wrap_addr0", 512'(aq[0]), 512'(32'hFFFF_FFC0));
      chk("wrap_addr1", 512'(aq[1]), 512'(32'h0000_0000));
    end
    chk("wrap_count", 512'(bus.o_line_count), 512'(2));

    // Async reset mid-run with H valid and cnt == 2
    clear_q();
    bus.i_line_ready = 1'b0;
    start_run(32'h3000);
    send_n(1, 6, ws);
    @(negedge clk);
    chk("pre_rst_valid", 512'(bus.o_line_valid), 512'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 512'(bus.o_ready), 512'(0));
    chk("arst_valid", 512'(bus.o_line_valid), 512'(0));
    chk("arst_line",  bus.o_line, 512'(0));
    chk("arst_addr",  512'(bus.o_addr), 512'(0));
    chk("arst_done",  512'(bus.o_run_done), 512'(0));
    chk("arst_count", 512'(bus.o_line_count), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.i_line_ready = 1'b1;
    clear_q();
    start_run(32'h4000);
    send_n(100, 4, ws);
    send(128'd0, wt);
    wait_done("post_rst");
    chk("post_rst_nlines", 512'(lq.size()), 512'(1));
    if (lq.size() == 1) begin
      chk("post_rst_line0", lq[0], mk_line(100));
      chk("post_rst_addr0", 512'(aq[0]), 512'(32'h4000));
    end
    chk("post_rst_count", 512'(bus.o_line_count), 512'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
